// File: rtl/pattern_detect_pkg.sv
// Shared constants and parameter legality check for the multi-channel pattern detector.
package pattern_detect_pkg;

  localparam int MAX_CHANNELS = 32;
  localparam int MAX_PAT_LEN  = 32;

  localparam logic [3:0] PAT_DEFAULT_4 = 4'b1011;

  function automatic bit params_ok(input int channels, input int pat_len, input int cnt_w);
    return (channels >= 1) && (channels <= MAX_CHANNELS) &&
           (pat_len >= 2) && (pat_len <= MAX_PAT_LEN) &&
           (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/pattern_detect_if.sv
// Sample/config inputs and match outputs of the detector, bundled for one-port hookup.
// Handshake: din is consumed only in cycles where din_vld is 1; there is no ready, the detector always accepts.
interface pattern_detect_if #(
  parameter int CHANNELS = 4,
  parameter int PAT_LEN  = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       din;
  logic                      din_vld;
  logic [PAT_LEN-1:0]        pattern;
  logic [PAT_LEN-1:0]        mask;
  logic                      overlap_en;
  logic                      clr;
  logic [CHANNELS-1:0]       match;
  logic [CHANNELS*CNT_W-1:0] match_cnt;
  logic                      any_seen;

  modport master (
    output din, din_vld, pattern, mask, overlap_en, clr,
    input  match, match_cnt, any_seen
  );

  modport slave (
    input  din, din_vld, pattern, mask, overlap_en, clr,
    output match, match_cnt, any_seen
  );
endinterface

// File: rtl/pattern_detect_chan.sv
// One detector lane: history shift register, warm-up fill counter, masked compare,
// registered match pulse and saturating match counter.
module pattern_detect_chan #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               din_i,
  input  logic               din_vld_i,
  input  logic [PAT_LEN-1:0] pattern_i,
  input  logic [PAT_LEN-1:0] mask_i,
  input  logic               overlap_en_i,
  output logic               hit_o,
  output logic               match_o,
  output logic [CNT_W-1:0]   cnt_o
);
  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_LEN-1:0] hist_q, hist_d, next_hist;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q;
  logic               warm;
  logic               hit;

  assign next_hist = {hist_q[PAT_LEN-2:0], din_i};
  // Warm when the current sample completes a full window.
  assign warm      = (fill_q >= FILL_LAST);
  assign hit       = din_vld_i & ~clr_i & warm & (((next_hist ^ pattern_i) & mask_i) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (din_vld_i) begin
      hist_d = next_hist;
      if (hit && !overlap_en_i) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
    if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= hit;
    end
  end

  assign hit_o   = hit;
  assign match_o = match_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/pattern_detect.sv
// Multi-channel serial pattern detector top: one lane per channel plus a sticky any-match flag.
module pattern_detect
  import pattern_detect_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PAT_LEN  = 4,
  parameter int CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  pattern_detect_if.slave bus
);
  if (!params_ok(CHANNELS, PAT_LEN, CNT_W)) begin : g_bad_params
    $error("pattern_detect: illegal CHANNELS/PAT_LEN/CNT_W");
  end

  logic [CHANNELS-1:0]       hit;
  logic [CHANNELS-1:0]       match_all;
  logic [CHANNELS*CNT_W-1:0] cnt_all;
  logic                      any_seen_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pattern_detect_chan #(
      .PAT_LEN (PAT_LEN),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clk_i        (clk),
      .rst_i        (rst),
      .clr_i        (bus.clr),
      .din_i        (bus.din[g]),
      .din_vld_i    (bus.din_vld),
      .pattern_i    (bus.pattern),
      .mask_i       (bus.mask),
      .overlap_en_i (bus.overlap_en),
      .hit_o        (hit[g]),
      .match_o      (match_all[g]),
      .cnt_o        (cnt_all[g*CNT_W +: CNT_W])
    );
  end

  // hit is already suppressed by clr inside each lane.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      any_seen_q <= 1'b0;
    end else if (|hit) begin
      any_seen_q <= 1'b1;
    end
  end

  assign bus.match     = match_all;
  assign bus.match_cnt = cnt_all;
  assign bus.any_seen  = any_seen_q;
endmodule

// File: tb/tb_pattern_detect.sv
// Directed bench for pattern_detect: CHANNELS=4, PAT_LEN=4, CNT_W=2 (small counter so saturation is reachable).
module tb_pattern_detect;
  import pattern_detect_pkg::*;

  localparam int CH = 4;
  localparam int PL = 4;
  localparam int CW = 2;

  logic clk;
  logic rst;
  int   cmp_cnt;
  int   fail_cnt;

  pattern_detect_if #(.CHANNELS(CH), .PAT_LEN(PL), .CNT_W(CW)) bus ();

  pattern_detect #(.CHANNELS(CH), .PAT_LEN(PL), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check the match vector just after the capturing edge.
  task automatic step(input logic [CH-1:0] d, input logic v, input logic [CH-1:0] exp_m, input string tag);
    bus.din     = d;
    bus.din_vld = v;
    @(posedge clk);
    #1;
    check(tag, 32'(bus.match), 32'(exp_m));
  endtask

  // Feed n valid samples (MSB of bits first) on one channel; exp gives the per-sample match.
  task automatic ch_stream(input int ch, input logic [15:0] bits, input logic [15:0] exp,
                           input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      logic b, e;
      b = bits[n-1-i];
      e = exp[n-1-i];
      step(CH'(b) << ch, 1'b1, e ? (CH'(1) << ch) : '0, $sformatf("%s[%0d]", tag, i));
    end
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    step('0, 1'b0, '0, "clr_cycle");
    bus.clr = 1'b0;
  endtask

  task automatic check_cnt(input int ch, input int exp, input string tag);
    check(tag, 32'(bus.match_cnt[ch*CW +: CW]), 32'(exp));
  endtask

  initial begin
    cmp_cnt        = 0;
    fail_cnt       = 0;
    rst            = 1'b1;
    bus.clr        = 1'b0;
    bus.din        = '0;
    bus.din_vld    = 1'b0;
    bus.pattern    = PAT_DEFAULT_4;
    bus.mask       = 4'hF;
    bus.overlap_en = 1'b1;

    step('0, 1'b0, '0, "rst_match0");
    step('0, 1'b0, '0, "rst_match1");
    rst = 1'b0;
    check("rst_cnt", 32'(bus.match_cnt), 32'd0);
    check("rst_any", 32'(bus.any_seen), 32'd0);

    // basic 1011 on ch0
    ch_stream(0, 16'b1011, 16'b0001, 4, "basic");
    check_cnt(0, 1, "basic_cnt0");
    check("basic_cnt_others", 32'(bus.match_cnt[CH*CW-1:CW]), 32'd0);
    check("basic_any", 32'(bus.any_seen), 32'd1);
    step('0, 1'b0, '0, "basic_pulse_end");

    do_clr();
    check("clr_cnt", 32'(bus.match_cnt), 32'd0);
    check("clr_any", 32'(bus.any_seen), 32'd0);

    // overlapping 1011 on ch1
    ch_stream(1, 16'b1011011, 16'b0001001, 7, "ovl1011");
    check_cnt(1, 2, "ovl1011_cnt");

    // 1111 overlap vs non-overlap on ch2
    bus.pattern = 4'b1111;
    do_clr();
    ch_stream(2, 16'b111111, 16'b000111, 6, "ones_ovl");
    check_cnt(2, 3, "ones_ovl_cnt");
    do_clr();
    bus.overlap_en = 1'b0;
    ch_stream(2, 16'hFF, 16'b00010001, 8, "ones_novl");
    check_cnt(2, 2, "ones_novl_cnt");
    bus.overlap_en = 1'b1;

    // masked pattern 1001/1001 on ch3
    bus.pattern = 4'b1001;
    bus.mask    = 4'b1001;
    do_clr();
    ch_stream(3, 16'b11111001, 16'b00011001, 8, "mask1001");
    check_cnt(3, 3, "mask1001_cnt");

    // mask all zero: every warm sample on every channel matches; counters saturate
    bus.mask = 4'h0;
    do_clr();
    step(4'h5, 1'b1, 4'h0, "mask0_s0");
    step(4'hA, 1'b1, 4'h0, "mask0_s1");
    step(4'h3, 1'b1, 4'h0, "mask0_s2");
    step(4'hC, 1'b1, 4'hF, "mask0_s3");
    step(4'h0, 1'b1, 4'hF, "mask0_s4");
    step(4'hF, 1'b1, 4'hF, "mask0_s5");
    step(4'h6, 1'b1, 4'hF, "mask0_s6");
    step(4'h9, 1'b1, 4'hF, "mask0_s7");
    check("mask0_sat_cnt", 32'(bus.match_cnt), 32'hFF);
    check("mask0_any", 32'(bus.any_seen), 32'd1);

    // din_vld gaps
    bus.pattern = PAT_DEFAULT_4;
    bus.mask    = 4'hF;
    do_clr();
    ch_stream(0, 16'b10, 16'b00, 2, "gap_pre");
    step(4'h1, 1'b0, 4'h0, "gap_idle0");
    step(4'h0, 1'b0, 4'h0, "gap_idle1");
    step(4'h1, 1'b0, 4'h0, "gap_idle2");
    ch_stream(0, 16'b11, 16'b01, 2, "gap_post");
    check_cnt(0, 1, "gap_cnt");

    // clr with completing valid sample
    ch_stream(0, 16'b101, 16'b000, 3, "clrv_pre");
    bus.clr = 1'b1;
    step(4'h1, 1'b1, 4'h0, "clrv_hit_blocked");
    bus.clr = 1'b0;
    check_cnt(0, 0, "clrv_cnt");
    check("clrv_any", 32'(bus.any_seen), 32'd0);
    ch_stream(0, 16'b1011, 16'b0001, 4, "clrv_refill");

    // reset mid-pattern
    ch_stream(0, 16'b101, 16'b000, 3, "rstm_pre");
    rst = 1'b1;
    step('0, 1'b0, '0, "rstm_rst");
    rst = 1'b0;
    check_cnt(0, 0, "rstm_cnt");
    check("rstm_any", 32'(bus.any_seen), 32'd0);
    ch_stream(0, 16'b1, 16'b0, 1, "rstm_post");

    // rst together with clr and a completing sample
    ch_stream(0, 16'b101, 16'b000, 3, "rstc_pre");
    rst     = 1'b1;
    bus.clr = 1'b1;
    step(4'h1, 1'b1, 4'h0, "rstc_blocked");
    rst     = 1'b0;
    bus.clr = 1'b0;
    check("rstc_cnt", 32'(bus.match_cnt), 32'd0);
    check("rstc_any", 32'(bus.any_seen), 32'd0);
    ch_stream(0, 16'b1011, 16'b0001, 4, "rstc_refill");
    check_cnt(0, 1, "rstc_refill_cnt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/pattern_detect.md
# pattern_detect

Multi-channel serial pattern detector: each channel shifts in one bit per qualified sample and raises a one-cycle match pulse when the most recent PAT_LEN samples equal a programmable, maskable pattern. Adds over the fixed 4-bit detector: parametrised length and channel count, runtime pattern/mask, warm-up gating, overlapping or non-overlapping mode, and per-channel saturating match counters. Sits directly behind synchronised serial inputs, e.g. framing/sync-word hunt and glitch signatures.

## Interface
- CHANNELS, 4: independent input lanes (1..32).
- PAT_LEN, 4: pattern length in samples (2..32).
- CNT_W, 8: width of each per-channel match counter.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  CHANNELS  one serial bit per channel.
- din_vld  in  1  sample qualifier, common to all channels; shift only when 1.
- pattern  in  PAT_LEN  target; bit PAT_LEN-1 = oldest sample, bit 0 = newest. Default wiring 4'b1011.
- mask  in  PAT_LEN  1 = compare this position, 0 = don't care.
- overlap_en  in  1  1 = overlapping matches allowed; 0 = history flushed after each match.
- clr  in  1  synchronous clear of history, warm-up, counters and sticky flag; config untouched.
- match  out  CHANNELS  one-cycle pulse per channel on match.
- match_cnt  out  CHANNELS*CNT_W  channel k at [k*CNT_W +: CNT_W]; saturating.
- any_seen  out  1  sticky: set on any match on any channel, cleared by rst/clr.

## Operation
- Per channel: history shift register hist[PAT_LEN-1:0]; on din_vld, hist <= {hist[PAT_LEN-2:0], din[k]}.
- Warm-up: per-channel fill counter 0..PAT_LEN, increments per valid sample, saturates at PAT_LEN. Compare enabled only when fill reaches PAT_LEN including the current sample (i.e. fill == PAT_LEN-1 before the shift is sufficient).
- Compare: hit = din_vld & warm & (((next_hist ^ pattern) & mask) == 0), with next_hist the post-shift value.
- mask all-zero: every warm valid sample matches (legal, documented).
- Non-overlap mode: on hit, fill counter resets to 0; next match requires PAT_LEN fresh samples. Overlap mode: fill stays saturated.
- Counter: +1 on hit, holds at 2^CNT_W-1.
- pattern/mask/overlap_en are sampled every cycle; changes take effect on the next compare, history is not cleared.
- Priority: rst > clr > normal. clr with din_vld in same cycle: clear wins, sample discarded, no match.

## Timing
- match registered: asserts the cycle after the clk edge that captured the completing sample (1-cycle latency from din_vld high), high exactly one cycle.
- match_cnt and any_seen update on the same edge as match rises.
- din_vld low: no shift, no compare, match 0, counters hold.
- Reset/clr values: hist 0, fill 0, match 0, match_cnt 0, any_seen 0. Earliest match after reset: PAT_LEN valid samples later.
- Reset mid-pattern: partial history lost; no spurious match from pre-reset samples.
- Back-to-back valid samples in overlap mode may pulse match on consecutive cycles.

## Structure
- Package pattern_detect_pkg: MAX_CHANNELS=32, MAX_PAT_LEN=32, default pattern constant PAT_DEFAULT_4 = 4'b1011, parameter range checks as localparam/function.
- Sub-module pattern_detect_chan: one lane (hist, fill counter, compare, counter, match flop); top generates CHANNELS instances and ORs hits into any_seen.
- No memories; pure flops. Parameter violations flagged at elaboration.

## Test plan
- Reset release, CHANNELS=4, PAT_LEN=4, pattern 1011, mask 1111, overlap_en=1; ch0 stream 1,0,1,1 with din_vld=1 -> match[0] pulses 1 cycle after 4th sample, match_cnt[0]=1, any_seen=1; other channels 0.
- Overlap: ch1 stream 1,0,1,1,0,1,1 -> 2 matches (samples 4 and 7) with overlap_en=1; pattern 1111, stream of 6 ones -> 3 matches overlap, 1 match non-overlap.
- Mask: pattern 1001, mask 1001, stream 1,1,1,1 then 1,0,0,1 -> both windows match; mask 0 -> every valid sample after warm-up matches, none in first 3.
- din_vld gaps: 1,0,(vld low 3 cycles, din toggling),1,1 -> exactly one match, no match during gap.
- Saturation: CNT_W=2, 5 matches -> match_cnt stays 3; clr asserted with din_vld and completing bit -> no match, counts 0, any_seen 0, next match needs 4 new samples.
- Reset mid-pattern: 1,0,1, rst for 1 cycle, 1 -> no match; rst overrides clr and simultaneous completing sample.
